pio_byte_responder: RTL

Device-side endpoint for the Tiny Tapeout pin interface: the block that answers a host driving ui_in/uio_in and sampling uo_out/uio_out. Accepts bytes from the host over a four-phase strobe/ack write handshake and buffers them in a small FIFO. Returns each byte, optionally XOR-transformed, over a four-phase valid/ack read handshake. Sits directly under a tt_um_* top as its core logic.

---
 rtl/pio_byte_responder_pkg.sv | 24 ++
 rtl/pio_byte_responder_fifo.sv | 63 ++++++
 rtl/pio_byte_responder.sv | 108 ++++++++++
 3 files changed

// File: rtl/pio_byte_responder_pkg.sv
// Shared encodings for the pin-interface byte responder: FSM states and uio bit map.
package pio_pkg;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_ACK  = 1'b1
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_VALID = 2'd1,
    RD_WAIT  = 2'd2
  } rd_state_t;

  localparam int UIO_STB     = 0;
  localparam int UIO_RDACK   = 1;
  localparam int UIO_WRACK   = 2;
  localparam int UIO_RDVALID = 3;
  localparam int UIO_FULL    = 4;
  localparam int UIO_EMPTY   = 5;

  localparam logic [7:0] UIO_OE_MASK = 8'h3C;

endpackage

// File: rtl/pio_byte_responder_fifo.sv
// Synchronous byte FIFO; caller guarantees no push when full and no pop when empty.
module pio_fifo
  import pio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      mem_d[wptr_q] = push_data;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[rptr_q];
  assign count     = count_q;
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);

endmodule

// File: rtl/pio_byte_responder.sv
// Device-side byte responder: four-phase write (stb/ack) into a FIFO, four-phase read (valid/ack) out.
//   state    | meaning
//   WR_IDLE  | waiting for host_stb with a free slot
//   WR_ACK   | byte pushed, wr_ack high until host drops stb
//   RD_IDLE  | waiting for a queued byte
//   RD_VALID | uo_out holds head byte, rd_valid high until host acks
//   RD_WAIT  | byte popped, waiting for host to drop rd_ack
module pio_byte_responder
  import pio_pkg::*;
#(
  parameter int         DEPTH   = 4,
  parameter logic [7:0] XOR_KEY = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;
  logic [7:0] uo_q, uo_d;

  logic                   host_stb;
  logic                   host_rd_ack;
  logic                   push;
  logic                   pop;
  logic [7:0]             fifo_head;
  logic [$clog2(DEPTH):0] unused_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   unused_uio;

  assign host_stb    = uio_in[UIO_STB];
  assign host_rd_ack = uio_in[UIO_RDACK];
  assign unused_uio  = &{1'b0, uio_in[7:2]};

  pio_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (ui_in ^ XOR_KEY),
    .pop       (pop),
    .head_data (fifo_head),
    .count     (unused_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // With ena low nothing advances, so the FIFO sees neither push nor pop.
  always_comb begin
    wr_state_d = wr_state_q;
    rd_state_d = rd_state_q;
    uo_d       = uo_q;
    push       = 1'b0;
    pop        = 1'b0;
    if (ena) begin
      case (wr_state_q)
        WR_IDLE: if (host_stb && !fifo_full) begin
          push       = 1'b1;
          wr_state_d = WR_ACK;
        end
        WR_ACK: if (!host_stb) wr_state_d = WR_IDLE;
        default: wr_state_d = WR_IDLE;
      endcase
      case (rd_state_q)
        RD_IDLE: if (!fifo_empty) begin
          uo_d       = fifo_head;
          rd_state_d = RD_VALID;
        end
        RD_VALID: if (host_rd_ack) begin
          pop        = 1'b1;
          rd_state_d = RD_WAIT;
        end
        RD_WAIT: if (!host_rd_ack) rd_state_d = RD_IDLE;
        default: rd_state_d = RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      uo_q       <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      uo_q       <= uo_d;
    end
  end

  always_comb begin
    uio_out              = '0;
    uio_out[UIO_WRACK]   = (wr_state_q == WR_ACK);
    uio_out[UIO_RDVALID] = (rd_state_q == RD_VALID);
    uio_out[UIO_FULL]    = fifo_full;
    uio_out[UIO_EMPTY]   = fifo_empty;
  end

  assign uo_out = uo_q;
  assign uio_oe = UIO_OE_MASK;

endmodule
